// File: rtl/lc4_mul_pkg.sv
// Shared definitions for the LC4 iterative multiplier: operation encodings
// and the controller state type.
package lc4_mul_pkg;

   localparam logic [1:0] OP_MUL = 2'b00;
   localparam logic [1:0] OP_MAC = 2'b01;
   localparam logic [1:0] OP_SQR = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } state_t;

endpackage

// File: rtl/lc4_mul_digit.sv
// One shift-add step of the multiplier: adds a * digit to the running high
// partial product. Purely combinational.
module lc4_mul_digit #(
   parameter int WORD_SIZE  = 64,
   parameter int DIGIT_BITS = 1
) (
   input  logic [WORD_SIZE:0]            p_hi,
   input  logic [WORD_SIZE-1:0]          a,
   input  logic [DIGIT_BITS-1:0]         digit,
   output logic [WORD_SIZE+DIGIT_BITS:0] sum
);

   localparam int SW = WORD_SIZE + DIGIT_BITS + 1;

   logic [SW-1:0] a_ext;
   logic [SW-1:0] digit_ext;
   logic [SW-1:0] p_hi_ext;

   // a * digit < 2^(W+D), so the product fits the sum width exactly.
   always_comb begin
      a_ext     = {{(DIGIT_BITS+1){1'b0}}, a};
      digit_ext = {{(WORD_SIZE+1){1'b0}}, digit};
      p_hi_ext  = {{DIGIT_BITS{1'b0}}, p_hi};
      sum       = p_hi_ext + a_ext * digit_ext;
   end

endmodule

// File: rtl/lc4_mul_seq.sv
// Iterative shift-add multiplier / MAC / squarer retiring DIGIT_BITS multiplier
// bits per cycle and returning a 2*WORD_SIZE product over valid/ready.
module lc4_mul_seq
   import lc4_mul_pkg::*;
#(
   parameter int WORD_SIZE  = 64,
   parameter int DIGIT_BITS = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic [1:0]           i_op,
   input  logic [WORD_SIZE-1:0] i_a,
   input  logic [WORD_SIZE-1:0] i_b,
   input  logic [WORD_SIZE-1:0] i_c,
   input  logic                 i_carry,
   input  logic                 i_abort,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic [WORD_SIZE-1:0] o_hi,
   output logic [WORD_SIZE-1:0] o_lo,
   output state_t               dbg_state
);

   localparam int W  = WORD_SIZE;
   localparam int D  = DIGIT_BITS;
   localparam int N  = W / D;
   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0] N_CNT   = CW'(N);
   localparam logic [CW-1:0] ONE_CNT = CW'(1);

   if ((W % D) != 0) begin : g_bad_digit
      $error("lc4_mul_seq: DIGIT_BITS must divide WORD_SIZE");
   end

   state_t          state_q, state_d;
   logic [CW-1:0]   count_q;
   logic [W-1:0]    a_q;
   logic [W:0]      p_hi_q;
   logic [W-1:0]    p_lo_q;
   logic [W+D:0]    sum;
   logic [W-1:0]    p_lo_next;
   logic            accept;
   logic            step;

   // Handshake: a request transfers on a rising edge with i_valid && o_ready
   // (o_ready = IDLE, from the state register only); a result transfers with
   // o_valid && i_ready, o_valid/o_hi/o_lo holding until then. i_abort wins.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      step    = 1'b0;
      if (i_abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: if (i_valid) begin
               accept  = 1'b1;
               state_d = BUSY;
            end
            BUSY: begin
               step = 1'b1;
               if (count_q == ONE_CNT) state_d = DONE;
            end
            DONE: if (i_ready) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   lc4_mul_digit #(.WORD_SIZE(W), .DIGIT_BITS(D)) u_digit (
      .p_hi  (p_hi_q),
      .a     (a_q),
      .digit (p_lo_q[D-1:0]),
      .sum   (sum)
   );

   // Low D bits of the sum shift into the top of P_lo as the multiplier drains.
   if (D < W) begin : g_shift_part
      assign p_lo_next = {sum[D-1:0], p_lo_q[W-1:D]};
   end else begin : g_shift_full
      assign p_lo_next = sum[W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         p_hi_q  <= '0;
         p_lo_q  <= '0;
         count_q <= '0;
      end else if (accept) begin
         a_q     <= i_a;
         p_lo_q  <= (i_op == OP_SQR) ? i_a : i_b;
         p_hi_q  <= (i_op == OP_MAC) ? ({1'b0, i_c} + {{W{1'b0}}, i_carry}) : '0;
         count_q <= N_CNT;
      end else if (step) begin
         p_hi_q  <= sum[W+D:D];
         p_lo_q  <= p_lo_next;
         count_q <= count_q - ONE_CNT;
      end
   end

   assign o_ready   = (state_q == IDLE);
   assign o_valid   = (state_q == DONE);
   assign o_hi      = p_hi_q[W-1:0];
   assign o_lo      = p_lo_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_lc4_mul_seq.sv
// Directed bench for lc4_mul_seq: three instances (W64/D1, W64/D4, W32/D2)
// selected per transaction; results checked against hand values and a model.
module tb_lc4_mul_seq;
   import lc4_mul_pkg::*;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         i_valid, i_abort, i_ready, i_carry;
   logic [1:0]   i_op;
   logic [63:0]  i_a, i_b, i_c;
   logic [2:0]   v_sel;
   int           sel;

   logic         rdy0, rdy1, rdy2, ov0, ov1, ov2;
   logic [63:0]  hi0, lo0, hi1, lo1;
   logic [31:0]  hi2, lo2;
   state_t       st0, st1, st2;

   logic         o_ready, o_valid;
   logic [127:0] res;

   logic [127:0] exp_q[$];
   int           n_pass = 0;
   int           n_total = 0;

   typedef struct {
      logic [1:0]   op;
      logic [63:0]  a, b, c;
      logic         cy;
      logic [127:0] exp;
   } vec_t;
   vec_t tv[11];

   always #5 clk = ~clk;

   always_comb v_sel = i_valid ? (3'b001 << sel) : 3'b000;

   always_comb begin
      case (sel)
         1: begin o_ready = rdy1; o_valid = ov1; res = {hi1, lo1}; end
         2: begin o_ready = rdy2; o_valid = ov2; res = {64'h0, hi2, lo2}; end
         default: begin o_ready = rdy0; o_valid = ov0; res = {hi0, lo0}; end
      endcase
   end

   lc4_mul_seq #(.WORD_SIZE(64), .DIGIT_BITS(1)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .i_valid(v_sel[0]), .o_ready(rdy0), .i_op(i_op),
      .i_a(i_a), .i_b(i_b), .i_c(i_c), .i_carry(i_carry), .i_abort(i_abort),
      .o_valid(ov0), .i_ready(i_ready), .o_hi(hi0), .o_lo(lo0), .dbg_state(st0));

   lc4_mul_seq #(.WORD_SIZE(64), .DIGIT_BITS(4)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .i_valid(v_sel[1]), .o_ready(rdy1), .i_op(i_op),
      .i_a(i_a), .i_b(i_b), .i_c(i_c), .i_carry(i_carry), .i_abort(i_abort),
      .o_valid(ov1), .i_ready(i_ready), .o_hi(hi1), .o_lo(lo1), .dbg_state(st1));

   lc4_mul_seq #(.WORD_SIZE(32), .DIGIT_BITS(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .i_valid(v_sel[2]), .o_ready(rdy2), .i_op(i_op),
      .i_a(i_a[31:0]), .i_b(i_b[31:0]), .i_c(i_c[31:0]), .i_carry(i_carry),
      .i_abort(i_abort), .o_valid(ov2), .i_ready(i_ready), .o_hi(hi2), .o_lo(lo2),
      .dbg_state(st2));

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic wait_cycle();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] model(input int s, input logic [1:0] op,
                                          input logic [63:0] a, b, c, input logic cy);
      logic [127:0] aa, bb, cc;
      aa = (s == 2) ? {96'h0, a[31:0]} : {64'h0, a};
      bb = (s == 2) ? {96'h0, b[31:0]} : {64'h0, b};
      cc = (s == 2) ? {96'h0, c[31:0]} : {64'h0, c};
      if (op == OP_MAC)      model = aa * bb + cc + {127'h0, cy};
      else if (op == OP_SQR) model = aa * aa;
      else                   model = aa * bb;
   endfunction

   // Called just after the accept edge; the first sample is cycle T+1.
   task automatic wait_result(input string name, input int exp_lat);
      int lat;
      logic [127:0] exp;
      lat = 1;
      while (!o_valid && lat < 300) begin
         wait_cycle();
         lat++;
      end
      check({name, " latency"}, lat, exp_lat);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      check({name, " product"}, res, exp);
   endtask

   task automatic start_op(input int s, input logic [1:0] op, input logic [63:0] a, b, c,
                           input logic cy);
      sel = s; i_op = op; i_a = a; i_b = b; i_c = c; i_carry = cy;
      i_valid = 1'b1;
      wait_cycle();
      i_valid = 1'b0;
   endtask

   task automatic run_op(input string name, input int s, input logic [1:0] op,
                         input logic [63:0] a, b, c, input logic cy, input logic [127:0] exp);
      int lat_n;
      lat_n = (s == 0) ? 65 : 17;
      exp_q.push_back(exp);
      start_op(s, op, a, b, c, cy);
      wait_result(name, lat_n);
      wait_cycle();
   endtask

   initial begin
      logic [63:0] ra, rb, rc;
      logic [1:0]  rop;
      logic        rcy, seen;

      tv[0]  = '{OP_MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0,
                 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001};
      tv[1]  = '{OP_MAC, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0001};
      tv[2]  = '{OP_SQR, 64'h1_0000_0000, 64'hDEAD, 64'h55, 1'b1, 128'h1_0000_0000_0000_0000};
      tv[3]  = '{OP_MUL, 64'd7, 64'd9, 64'h0, 1'b0, 128'd63};
      tv[4]  = '{OP_MUL, 64'h0, 64'hDEAD_BEEF, 64'h77, 1'b1, 128'h0};
      tv[5]  = '{2'b11, 64'd3, 64'd5, 64'd100, 1'b1, 128'd15};
      tv[6]  = '{OP_MAC, 64'h0, 64'h0, 64'd5, 1'b1, 128'd6};
      tv[7]  = '{OP_MUL, 64'h8000_0000_0000_0000, 64'd2, 64'h0, 1'b0, 128'h1_0000_0000_0000_0000};
      tv[8]  = '{OP_MAC, 64'd2, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 128'h1_0000_0000_0000_0006};
      tv[9]  = '{OP_SQR, 64'hFFFF_FFFF, 64'h1234, 64'h0, 1'b0, 128'hFFFF_FFFE_0000_0001};
      tv[10] = '{OP_MUL, 64'd3, 64'd5, 64'h0, 1'b0, 128'd15};

      // Clock / reset
      rst_n = 1'b0; i_valid = 1'b0; i_abort = 1'b0; i_ready = 1'b1; i_carry = 1'b0;
      i_op = OP_MUL; i_a = '0; i_b = '0; i_c = '0; sel = 0;
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      wait_cycle();
      check("reset o_ready", o_ready, 1'b1);
      check("reset o_valid", o_valid, 1'b0);
      check("reset product", res, 128'h0);
      check("reset states", {st0, st1, st2}, {IDLE, IDLE, IDLE});

      // Directed table on both 64-bit instances
      for (int s = 0; s < 2; s++)
         for (int i = 0; i < 11; i++)
            run_op($sformatf("vec%0d d%0d", i, s), s, tv[i].op, tv[i].a, tv[i].b,
                   tv[i].c, tv[i].cy, tv[i].exp);

      // Randomised operands, all modes, all instances
      for (int s = 0; s < 3; s++)
         for (int i = 0; i < 6; i++) begin
            ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; rc = {$urandom, $urandom};
            rop = 2'($urandom_range(0, 3)); rcy = 1'($urandom_range(0, 1));
            run_op($sformatf("rand%0d d%0d", i, s), s, rop, ra, rb, rc, rcy,
                   model(s, rop, ra, rb, rc, rcy));
         end

      // Backpressure: result held, new request refused while DONE
      i_ready = 1'b0;
      exp_q.push_back(128'd56088);
      start_op(0, OP_MUL, 64'd123, 64'd456, 64'h0, 1'b0);
      wait_result("bp first", 65);
      i_a = 64'd5; i_b = 64'd5; i_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         wait_cycle();
         check("bp hold valid", o_valid, 1'b1);
         check("bp hold product", res, 128'd56088);
         check("bp hold ready", o_ready, 1'b0);
      end
      i_ready = 1'b1;
      wait_cycle();
      check("bp release ready", o_ready, 1'b1);
      check("bp release valid", o_valid, 1'b0);
      wait_cycle();
      i_valid = 1'b0;
      check("bp second accepted", o_ready, 1'b0);
      exp_q.push_back(128'd25);
      wait_result("bp second", 65);
      wait_cycle();

      // Abort in BUSY cycle 20
      start_op(0, OP_MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0);
      repeat (19) wait_cycle();
      check("abort pre state", st0, BUSY);
      i_abort = 1'b1;
      wait_cycle();
      i_abort = 1'b0;
      check("abort ready", o_ready, 1'b1);
      check("abort valid", o_valid, 1'b0);
      seen = 1'b0;
      for (int k = 0; k < 80; k++) begin
         wait_cycle();
         if (o_valid) seen = 1'b1;
      end
      check("abort no result", seen, 1'b0);
      run_op("post abort 7*9", 0, OP_MUL, 64'd7, 64'd9, 64'h0, 1'b0, 128'd63);

      // Abort and valid together: not accepted
      sel = 0; i_valid = 1'b1; i_abort = 1'b1;
      wait_cycle();
      i_valid = 1'b0; i_abort = 1'b0;
      check("abort blocks accept", o_ready, 1'b1);

      // Asynchronous reset mid-BUSY
      start_op(0, OP_MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0);
      repeat (10) wait_cycle();
      rst_n = 1'b0;
      #1;
      check("async rst ready", o_ready, 1'b1);
      check("async rst valid", o_valid, 1'b0);
      check("async rst product", res, 128'h0);
      @(negedge clk) rst_n = 1'b1;
      wait_cycle();
      check("post rst valid", o_valid, 1'b0);
      run_op("post rst 3*5 d4", 1, OP_MUL, 64'd3, 64'd5, 64'h0, 1'b0, 128'd15);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
